instruction_fetch: RTL and testbench

Instruction fetch stage feeding the control unit. Holds the program counter, issues one instruction-memory read at a time over a req/ack handshake, and presents the returned 32-bit word to the control unit with a valid/ready handshake. When an instruction is accepted, it forms the next PC from the control unit's `pc_control` and the instruction's immediate, jump, or register-target fields.

---
 rtl/cpu_pkg.sv | 17 +
 rtl/next_pc_calc.sv | 40 ++++
 rtl/instruction_fetch.sv | 102 ++++++++++
 tb/tb_instruction_fetch.sv | 303 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: next-PC select encodings used by fetch and the control unit,
// and the fetch-stage state type.
package cpu_pkg;

  localparam logic [2:0] PC_NEXT   = 3'b000;
  localparam logic [2:0] PC_BRANCH = 3'b001;
  localparam logic [2:0] PC_JUMP   = 3'b010;
  localparam logic [2:0] PC_JR     = 3'b011;
  localparam logic [2:0] PC_HALT   = 3'b100;

  typedef enum logic [1:0] {
    StFetch,
    StValid,
    StHalt
  } fetch_state_e;

endpackage

// File: rtl/next_pc_calc.sv
// Combinational next-PC selection for the fetch stage; also flags halt requests and
// misaligned jump-register targets.
module next_pc_calc
  import cpu_pkg::*;
(
  input  logic [31:0] pc_out_i,
  input  logic [2:0]  pc_control_i,
  input  logic [15:0] branch_offset_i,
  input  logic [25:0] jump_target_i,
  input  logic [31:0] jr_target_i,
  output logic [31:0] next_pc_o,
  output logic        halt_o,
  output logic        misaligned_o
);

  logic [31:0] pc_plus4;
  logic [31:0] branch_disp;

  assign pc_plus4    = pc_out_i + 32'd4;
  assign branch_disp = {{14{branch_offset_i[15]}}, branch_offset_i, 2'b00};

  always_comb begin
    next_pc_o    = pc_plus4;
    halt_o       = 1'b0;
    misaligned_o = 1'b0;
    case (pc_control_i)
      PC_BRANCH: next_pc_o = pc_plus4 + branch_disp;
      PC_JUMP:   next_pc_o = {pc_plus4[31:28], jump_target_i, 2'b00};
      PC_JR: begin
        next_pc_o    = jr_target_i;
        misaligned_o = |jr_target_i[1:0];
        halt_o       = |jr_target_i[1:0];
      end
      PC_HALT:   halt_o = 1'b1;
      // Reserved encodings fall through to sequential fetch.
      default:   next_pc_o = pc_plus4;
    endcase
  end

endmodule

// File: rtl/instruction_fetch.sv
// Instruction fetch stage: one outstanding imem read at a time, holds the returned word
// for the control unit and steers the PC when the word is accepted.
module instruction_fetch
  import cpu_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] instruction,
  output logic        instr_valid,
  input  logic        instr_ready,
  output logic [31:0] pc_out,
  input  logic [2:0]  pc_control,
  input  logic [15:0] branch_offset,
  input  logic [25:0] jump_target,
  input  logic [31:0] jr_target,
  output logic        halted,
  output logic        fault
);

  fetch_state_e state_q, state_d;
  logic [31:0]  pc_q, pc_d;
  logic [31:0]  instr_q, instr_d;
  logic [31:0]  pc_out_q, pc_out_d;
  logic         fault_q, fault_d;

  logic [31:0]  next_pc;
  logic         halt_req;
  logic         misaligned;

  next_pc_calc u_next_pc_calc (
    .pc_out_i        (pc_out_q),
    .pc_control_i    (pc_control),
    .branch_offset_i (branch_offset),
    .jump_target_i   (jump_target),
    .jr_target_i     (jr_target),
    .next_pc_o       (next_pc),
    .halt_o          (halt_req),
    .misaligned_o    (misaligned)
  );

  always_comb begin
    state_d  = state_q;
    pc_d     = pc_q;
    instr_d  = instr_q;
    pc_out_d = pc_out_q;
    fault_d  = fault_q;
    case (state_q)
      StFetch: begin
        if (imem_ack) begin
          instr_d  = imem_rdata;
          pc_out_d = pc_q;
          state_d  = StValid;
        end
      end
      StValid: begin
        if (instr_ready) begin
          if (halt_req) begin
            // PC is deliberately left untouched on halt or a bad JR target.
            state_d = StHalt;
            fault_d = fault_q | misaligned;
          end else begin
            pc_d    = next_pc;
            state_d = StFetch;
          end
        end
      end
      StHalt:  state_d = StHalt;
      default: state_d = StFetch;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= StFetch;
      pc_q     <= RESET_PC;
      instr_q  <= 32'h0;
      pc_out_q <= RESET_PC;
      fault_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      pc_q     <= pc_d;
      instr_q  <= instr_d;
      pc_out_q <= pc_out_d;
      fault_q  <= fault_d;
    end
  end

  assign imem_req    = (state_q == StFetch);
  assign imem_addr   = pc_q;
  assign instr_valid = (state_q == StValid);
  assign halted      = (state_q == StHalt);
  assign instruction = instr_q;
  assign pc_out      = pc_out_q;
  assign fault       = fault_q;

endmodule

// File: tb/tb_instruction_fetch.sv
// Scoreboard bench for instruction_fetch: a memory driver pushes expected words, a monitor
// pops them when instr_valid rises, and a PC model tracks every accept.
module tb_instruction_fetch;

  localparam logic [31:0] ResetPc = 32'h0000_0000;

  logic        clk;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack;
  logic [31:0] imem_rdata;
  logic [31:0] instruction;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] pc_out;
  logic [2:0]  pc_control;
  logic [15:0] branch_offset;
  logic [25:0] jump_target;
  logic [31:0] jr_target;
  logic        halted;
  logic        fault;

  instruction_fetch #(
    .RESET_PC (ResetPc)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .imem_req      (imem_req),
    .imem_addr     (imem_addr),
    .imem_ack      (imem_ack),
    .imem_rdata    (imem_rdata),
    .instruction   (instruction),
    .instr_valid   (instr_valid),
    .instr_ready   (instr_ready),
    .pc_out        (pc_out),
    .pc_control    (pc_control),
    .branch_offset (branch_offset),
    .jump_target   (jump_target),
    .jr_target     (jr_target),
    .halted        (halted),
    .fault         (fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic [31:0] instr;
    logic [31:0] pc;
  } exp_t;

  exp_t        exp_q[$];
  int          n_checks = 0;
  int          n_pass = 0;
  logic [31:0] model_pc;
  bit          model_fault;
  bit          tight = 1'b0;

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endfunction

  // Monitor: pops the scoreboard on each new held instruction, checks it stays put.
  initial begin : monitor
    bit          held;
    logic [31:0] h_instr;
    logic [31:0] h_pc;
    int          cyc;
    int          last_rise;
    exp_t        e;
    held      = 1'b0;
    cyc       = 0;
    last_rise = -1;
    forever begin
      @(negedge clk);
      cyc++;
      if (rst) begin
        held      = 1'b0;
        last_rise = -1;
      end else if (instr_valid) begin
        if (!held) begin
          if (exp_q.size() == 0) begin
            check("unexpected_valid", {31'b0, instr_valid}, 32'd0);
          end else begin
            e = exp_q.pop_front();
            check("instruction", instruction, e.instr);
            check("pc_out", pc_out, e.pc);
          end
          if (tight && last_rise >= 0) check("valid_gap", 32'(cyc - last_rise), 32'd2);
          last_rise = cyc;
          h_instr   = instruction;
          h_pc      = pc_out;
          held      = 1'b1;
        end else begin
          check("instr_hold", instruction, h_instr);
          check("pc_out_hold", pc_out, h_pc);
        end
      end else begin
        held = 1'b0;
      end
    end
  end

  initial begin : watchdog
    #1000000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  task automatic fetch_one(input int lat, input logic [31:0] data);
    int t = 0;
    while (!imem_req && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("req_seen", {31'b0, imem_req}, 32'd1);
    if (!imem_req) return;
    check("imem_addr", imem_addr, model_pc);
    for (int i = 1; i < lat; i++) begin
      @(negedge clk);
      check("addr_stable", imem_addr, model_pc);
      check("req_held", {31'b0, imem_req}, 32'd1);
    end
    imem_ack   = 1'b1;
    imem_rdata = data;
    exp_q.push_back('{instr: data, pc: model_pc});
    @(negedge clk);
    imem_ack   = 1'b0;
    imem_rdata = $urandom;
  endtask

  task automatic accept(input int hold, input logic [2:0] ctrl, input logic [15:0] off,
                        input logic [25:0] jt, input logic [31:0] jr);
    logic [31:0] p4;
    logic [31:0] nxt;
    bit          stop;
    bit          bad;
    int          t = 0;
    while (!instr_valid && t < 20) begin
      @(negedge clk);
      t++;
    end
    check("valid_seen", {31'b0, instr_valid}, 32'd1);
    if (!instr_valid) return;
    for (int i = 0; i < hold; i++) begin
      instr_ready = 1'b0;
      @(negedge clk);
      check("valid_while_stalled", {31'b0, instr_valid}, 32'd1);
    end
    instr_ready   = 1'b1;
    pc_control    = ctrl;
    branch_offset = off;
    jump_target   = jt;
    jr_target     = jr;
    p4   = model_pc + 32'd4;
    nxt  = p4;
    stop = 1'b0;
    bad  = 1'b0;
    case (ctrl)
      3'b001: nxt = p4 + 32'(int'($signed(off)) * 4);
      3'b010: nxt = {p4[31:28], jt, 2'b00};
      3'b011: begin
        if ((jr & 32'd3) != 32'd0) begin
          stop = 1'b1;
          bad  = 1'b1;
        end else begin
          nxt = jr;
        end
      end
      3'b100: stop = 1'b1;
      default: nxt = p4;
    endcase
    @(negedge clk);
    instr_ready = 1'b0;
    if (stop) begin
      model_fault = model_fault | bad;
      check("halted", {31'b0, halted}, 32'd1);
      check("halt_no_req", {31'b0, imem_req}, 32'd0);
      check("halt_no_valid", {31'b0, instr_valid}, 32'd0);
    end else begin
      model_pc = nxt;
      check("not_halted", {31'b0, halted}, 32'd0);
    end
    check("fault", {31'b0, fault}, {31'b0, model_fault});
  endtask

  task automatic halt_idle(input int n);
    for (int i = 0; i < n; i++) begin
      imem_ack   = 1'($urandom_range(0, 1));
      imem_rdata = $urandom;
      @(negedge clk);
      check("idle_no_req", {31'b0, imem_req}, 32'd0);
      check("idle_no_valid", {31'b0, instr_valid}, 32'd0);
      check("idle_halted", {31'b0, halted}, 32'd1);
      check("idle_fault", {31'b0, fault}, {31'b0, model_fault});
    end
    imem_ack = 1'b0;
  endtask

  task automatic check_reset_vals();
    check("rst_req", {31'b0, imem_req}, 32'd1);
    check("rst_addr", imem_addr, ResetPc);
    check("rst_valid", {31'b0, instr_valid}, 32'd0);
    check("rst_instr", instruction, 32'd0);
    check("rst_pc_out", pc_out, ResetPc);
    check("rst_halted", {31'b0, halted}, 32'd0);
    check("rst_fault", {31'b0, fault}, 32'd0);
  endtask

  // Asserts reset mid-cycle and checks outputs before any clock edge.
  task automatic pulse_reset();
    #2 rst = 1'b1;
    #1 check_reset_vals();
    @(negedge clk);
    #2 rst = 1'b0;
    exp_q.delete();
    model_pc    = ResetPc;
    model_fault = 1'b0;
    @(negedge clk);
  endtask

  initial begin : driver
    logic [2:0] ctrl;
    int         sel;
    rst           = 1'b1;
    imem_ack      = 1'b0;
    imem_rdata    = 32'h0;
    instr_ready   = 1'b0;
    pc_control    = 3'b000;
    branch_offset = 16'h0;
    jump_target   = 26'h0;
    jr_target     = 32'h0;
    model_pc      = ResetPc;
    model_fault   = 1'b0;
    repeat (2) @(negedge clk);
    check_reset_vals();
    #2 rst = 1'b0;
    @(negedge clk);

    // Back-to-back NEXT with a 1-cycle memory.
    tight = 1'b1;
    repeat (3) begin
      fetch_one(1, 32'h2008_0005);
      accept(0, 3'b000, 16'h0, 26'h0, 32'h0);
    end
    tight = 1'b0;

    // Slow memory and a stalled consumer.
    fetch_one(3, $urandom);
    accept(4, 3'b000, 16'h0, 26'h0, 32'h0);

    // Directed branch / jump / wrap cases, each positioned via JR.
    fetch_one(1, $urandom);
    accept(0, 3'b011, 16'h0, 26'h0, 32'h0000_0100);
    fetch_one(1, $urandom);
    accept(0, 3'b001, 16'hFFFE, 26'h0, 32'h0);
    fetch_one(1, $urandom);
    accept(0, 3'b011, 16'h0, 26'h0, 32'h0000_0100);
    fetch_one(2, $urandom);
    accept(1, 3'b001, 16'h0003, 26'h0, 32'h0);
    fetch_one(1, $urandom);
    accept(0, 3'b011, 16'h0, 26'h0, 32'hF000_0010);
    fetch_one(1, $urandom);
    accept(0, 3'b010, 16'h0, 26'h0000040, 32'h0);
    fetch_one(1, $urandom);
    accept(0, 3'b011, 16'h0, 26'h0, 32'hFFFF_FFFC);
    fetch_one(1, $urandom);
    accept(0, 3'b000, 16'h0, 26'h0, 32'h0);
    fetch_one(1, $urandom);
    accept(0, 3'b011, 16'h0, 26'h0, 32'h0000_0202);
    halt_idle(5);
    pulse_reset();

    // Reset while holding an instruction.
    fetch_one(2, $urandom);
    pulse_reset();

    // Reset while a request to a non-reset PC is outstanding.
    fetch_one(1, $urandom);
    accept(0, 3'b011, 16'h0, 26'h0, 32'h0000_0040);
    pulse_reset();

    for (int n = 0; n < 40; n++) begin
      fetch_one(int'($urandom_range(1, 3)), $urandom);
      sel  = int'($urandom_range(0, 7));
      ctrl = (sel == 4) ? 3'b001 : 3'(sel);
      accept(int'($urandom_range(0, 2)), ctrl, 16'($urandom), 26'($urandom),
             $urandom & 32'hFFFF_FFFC);
    end

    fetch_one(1, $urandom);
    accept(0, 3'b100, 16'h0, 26'h0, 32'h0);
    halt_idle(3);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
